// File: rtl/pu_riscv_mul_issue.sv
// Multiply issue stage: decodes RV M-extension multiplies from ID, prepares operands
// and buffers them in a 2-entry FIFO that feeds the multiplier.
module pu_riscv_mul_issue #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_bubble,
    input  logic [ILEN-1:0] id_instr,
    input  logic [XLEN-1:0] id_opA,
    input  logic [XLEN-1:0] id_opB,
    input  logic [1:0]      st_xlen,
    input  logic            ex_flush,
    input  logic            mul_ready,
    output logic            id_stall,
    output logic            mul_valid,
    output logic [1:0]      mul_op,
    output logic            mul_word,
    output logic [4:0]      mul_rd,
    output logic [XLEN-1:0] mul_opA,
    output logic [XLEN-1:0] mul_opB,
    output logic            mul_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [1:0] XLEN_RV32 = 2'b01;
    localparam logic [1:0] XLEN_RV64 = 2'b10;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_rs;

    assign opcode    = id_instr[6:0];
    assign rd        = id_instr[11:7];
    assign funct3    = id_instr[14:12];
    assign funct7    = id_instr[31:25];
    assign unused_rs = ^id_instr[24:15];

    logic is_mul;
    logic is_word;
    logic dec_legal;
    logic dec_illegal;
    logic narrow;

    assign is_mul      = !id_bubble && (opcode == OPC_OP || opcode == OPC_OP32) &&
                         (funct7 == F7_MULDIV) && !funct3[2];
    assign is_word     = (opcode == OPC_OP32);
    assign dec_legal   = is_mul && (!is_word || (funct3 == 3'b000 && st_xlen == XLEN_RV64));
    assign dec_illegal = is_mul && !dec_legal;
    assign narrow      = is_word || (st_xlen == XLEN_RV32);

    // Handshake: an entry moves to the multiplier on a rising edge where mul_valid and
    // mul_ready are both high; while mul_valid is high and mul_ready low the mul_*
    // payload is held. id_stall depends only on registered occupancy, never on mul_ready.
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       enq;
    logic       deq;

    assign enq = dec_legal && (count != 2'd2) && !ex_flush;
    assign deq = mul_valid && mul_ready;

    logic [1:0]      q_op   [2];
    logic            q_word [2];
    logic [4:0]      q_rd   [2];
    logic [XLEN-1:0] q_opA  [2];
    logic [XLEN-1:0] q_opB  [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                q_op[i]   <= '0;
                q_word[i] <= 1'b0;
                q_rd[i]   <= '0;
                q_opA[i]  <= '0;
                q_opB[i]  <= '0;
            end
        end else if (enq) begin
            q_op[wr_ptr]   <= funct3[1:0];
            q_word[wr_ptr] <= is_word;
            q_rd[wr_ptr]   <= rd;
            q_opA[wr_ptr]  <= narrow ? sext32(id_opA) : id_opA;
            q_opB[wr_ptr]  <= narrow ? sext32(id_opB) : id_opB;
        end
    end

    // Flush wins over any same-cycle enqueue or dequeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            mul_illegal <= 1'b0;
        end else begin
            mul_illegal <= dec_illegal && !ex_flush;
            if (ex_flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (enq) wr_ptr <= ~wr_ptr;
                if (deq) rd_ptr <= ~rd_ptr;
                case ({enq, deq})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign mul_valid = (count != 2'd0);
    assign id_stall  = (count == 2'd2);
    assign mul_op    = q_op[rd_ptr];
    assign mul_word  = q_word[rd_ptr];
    assign mul_rd    = q_rd[rd_ptr];
    assign mul_opA   = q_opA[rd_ptr];
    assign mul_opB   = q_opB[rd_ptr];

endmodule

// File: tb/tb_pu_riscv_mul_issue.sv
// Bench for pu_riscv_mul_issue: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_pu_riscv_mul_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_bubble;
  logic [31:0] id_instr;
  logic [63:0] id_opA, id_opB;
  logic [1:0]  st_xlen;
  logic        ex_flush, mul_ready;
  logic        id_stall, mul_valid, mul_word, mul_illegal;
  logic [1:0]  mul_op;
  logic [4:0]  mul_rd;
  logic [63:0] mul_opA, mul_opB;

  pu_riscv_mul_issue #(.XLEN(64), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .id_bubble(id_bubble), .id_instr(id_instr),
    .id_opA(id_opA), .id_opB(id_opB), .st_xlen(st_xlen), .ex_flush(ex_flush),
    .mul_ready(mul_ready), .id_stall(id_stall), .mul_valid(mul_valid),
    .mul_op(mul_op), .mul_word(mul_word), .mul_rd(mul_rd), .mul_opA(mul_opA),
    .mul_opB(mul_opB), .mul_illegal(mul_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic        word;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
  } ent_t;

  ent_t exp_q[$];
  logic exp_ill = 1'b0;
  logic run = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mon_e;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OP32 = 7'b0111011;
  localparam logic [1:0] RV32 = 2'b01;
  localparam logic [1:0] RV64 = 2'b10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // Reference model: apply the decode/accept rules to one ID slot, then update the
  // expected queue after the edge. The monitor owns dequeues.
  task automatic step(input logic bub, input logic [31:0] ins, input logic [63:0] a,
                      input logic [63:0] b, input logic [1:0] xl, input logic fl,
                      input logic rdy);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       is_m, is_w, ok, sx, take;
    ent_t       e;
    id_bubble = bub; id_instr = ins; id_opA = a; id_opB = b;
    st_xlen = xl; ex_flush = fl; mul_ready = rdy;
    opc  = ins[6:0];
    f3   = ins[14:12];
    is_m = !bub && (opc == OP || opc == OP32) && ins[31:25] == 7'd1 && !f3[2];
    is_w = (opc == OP32);
    ok   = is_m && (!is_w || (f3 == 3'd0 && xl == RV64));
    sx   = is_w || xl == RV32;
    e.op   = f3[1:0];
    e.word = is_w;
    e.rd   = ins[11:7];
    e.a    = sx ? {{32{a[31]}}, a[31:0]} : a;
    e.b    = sx ? {{32{b[31]}}, b[31:0]} : b;
    take   = ok && !fl && exp_q.size() < 2;
    @(posedge clk); #1;
    if (fl) exp_q.delete();
    else if (take) exp_q.push_back(e);
    exp_ill = is_m && !ok && !fl;
  endtask

  task automatic idle(input logic rdy);
    step(1'b1, 32'd0, 64'd0, 64'd0, RV64, 1'b0, rdy);
  endtask

  always @(negedge clk) begin
    if (!rst && run) begin
      chk("mul_valid", {63'd0, mul_valid}, {63'd0, exp_q.size() != 0});
      chk("id_stall", {63'd0, id_stall}, {63'd0, exp_q.size() == 2});
      chk("mul_illegal", {63'd0, mul_illegal}, {63'd0, exp_ill});
      if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        chk("mul_op", {62'd0, mul_op}, {62'd0, mon_e.op});
        chk("mul_word", {63'd0, mul_word}, {63'd0, mon_e.word});
        chk("mul_rd", {59'd0, mul_rd}, {59'd0, mon_e.rd});
        chk("mul_opA", mul_opA, mon_e.a);
        chk("mul_opB", mul_opB, mon_e.b);
        if (mul_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [63:0] ra, rb;
    rst = 1'b1; id_bubble = 1'b1; id_instr = '0; id_opA = '0; id_opB = '0;
    st_xlen = RV64; ex_flush = 1'b0; mul_ready = 1'b0;
    #2;
    chk("rst_valid", {63'd0, mul_valid}, 64'd0);
    chk("rst_stall", {63'd0, id_stall}, 64'd0);
    chk("rst_illegal", {63'd0, mul_illegal}, 64'd0);
    chk("rst_payload", {mul_op, mul_word, mul_rd} ^ mul_opA ^ mul_opB, 64'd0);
    #10;
    rst = 1'b0;
    run = 1'b1;

    // MULH x5 with opA=-3 right after reset release, consumed immediately
    step(1'b0, mk(7'd1, 3'b001, 5'd5, OP), -64'sd3, 64'd7, RV64, 1'b0, 1'b1);
    chk("mulh_opA", mul_opA, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mulh_rd", {59'd0, mul_rd}, 64'd5);
    chk("mulh_op", {62'd0, mul_op}, 64'd1);
    idle(1'b1);
    idle(1'b1);

    // MULW sign-extension from bit 31
    step(1'b0, mk(7'd1, 3'b000, 5'd9, OP32), 64'h0000_0001_8000_0000, 64'h5, RV64, 1'b0, 1'b0);
    chk("mulw_opA", mul_opA, 64'hFFFF_FFFF_8000_0000);
    chk("mulw_word", {63'd0, mul_word}, 64'd1);
    idle(1'b1);
    idle(1'b0);

    // Three back-to-back MULs against a stalled multiplier; the third is held by ID
    step(1'b0, mk(7'd1, 3'b000, 5'd1, OP), 64'd11, 64'd12, RV64, 1'b0, 1'b0);
    step(1'b0, mk(7'd1, 3'b010, 5'd2, OP), 64'd21, 64'd22, RV64, 1'b0, 1'b0);
    chk("stall_full", {63'd0, id_stall}, 64'd1);
    step(1'b0, mk(7'd1, 3'b011, 5'd3, OP), 64'd31, 64'd32, RV64, 1'b0, 1'b0);
    step(1'b0, mk(7'd1, 3'b011, 5'd3, OP), 64'd31, 64'd32, RV64, 1'b0, 1'b1);
    step(1'b0, mk(7'd1, 3'b011, 5'd3, OP), 64'd31, 64'd32, RV64, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // MULW in RV32 mode: dropped, one-cycle illegal pulse
    step(1'b0, mk(7'd1, 3'b000, 5'd7, OP32), 64'd1, 64'd2, RV32, 1'b0, 1'b1);
    chk("rv32_mulw_illegal", {63'd0, mul_illegal}, 64'd1);
    chk("rv32_mulw_valid", {63'd0, mul_valid}, 64'd0);
    idle(1'b1);
    chk("illegal_one_cycle", {63'd0, mul_illegal}, 64'd0);

    // Full queue, flush with a simultaneous legal MUL
    step(1'b0, mk(7'd1, 3'b000, 5'd4, OP), 64'd4, 64'd4, RV64, 1'b0, 1'b0);
    step(1'b0, mk(7'd1, 3'b001, 5'd6, OP), 64'd6, 64'd6, RV64, 1'b0, 1'b0);
    step(1'b0, mk(7'd1, 3'b000, 5'd8, OP), 64'd8, 64'd8, RV64, 1'b1, 1'b1);
    chk("flush_valid", {63'd0, mul_valid}, 64'd0);
    chk("flush_stall", {63'd0, id_stall}, 64'd0);

    // Asynchronous reset between edges with one entry queued
    step(1'b0, mk(7'd1, 3'b010, 5'd10, OP), 64'd99, 64'd98, RV64, 1'b0, 1'b0);
    id_bubble = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, mul_valid}, 64'd0);
    chk("arst_outputs", {mul_op, mul_word, mul_rd, id_stall, mul_illegal} ^ mul_opA ^ mul_opB, 64'd0);
    exp_q.delete();
    exp_ill = 1'b0;
    rst = 1'b0;
    step(1'b0, mk(7'd1, 3'b011, 5'd12, OP), 64'd5, 64'd6, RV32, 1'b0, 1'b0);
    chk("post_rst_accept", {63'd0, mul_valid}, 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    opc = OP;
        2:       opc = OP32;
        default: opc = 7'($urandom);
      endcase
      f7 = ($urandom_range(0, 5) != 0) ? 7'd1 : 7'($urandom);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      step($urandom_range(0, 9) == 0,
           mk(f7, 3'($urandom), 5'($urandom), opc), ra, rb,
           ($urandom_range(0, 3) == 0) ? RV32 : RV64,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6);
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drained", {63'd0, mul_valid}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
